// File: rtl/fb_pkg.sv
// Shared types, default geometry and helpers for the scaled frame-buffer reader.
package fb_pkg;

    typedef enum logic [1:0] {
        FB_NATIVE = 2'd0,
        FB_X2     = 2'd1,
        FB_CENTRE = 2'd2
    } fb_mode_e;

    localparam int DEF_SRC_W  = 320;
    localparam int DEF_SRC_H  = 240;
    localparam int DEF_DISP_W = 640;
    localparam int DEF_DISP_H = 480;
    localparam int DEF_ADDR_W = 17;
    localparam int DEF_PIX_W  = 12;
    localparam int DEF_RD_LAT = 1;

    typedef logic [DEF_PIX_W-1:0] pixel_t;

    // Control bits that travel alongside the BRAM read.
    typedef struct packed {
        logic hit;
        logic act;
        logic hs;
        logic vs;
    } fb_ctl_t;

    localparam fb_ctl_t CTL_RST = '{hit: 1'b0, act: 1'b0, hs: 1'b1, vs: 1'b1};

    // The reserved encoding falls back to native placement.
    function automatic fb_mode_e fb_decode_mode(input logic [1:0] raw);
        fb_mode_e m;
        case (raw)
            2'd1:    m = FB_X2;
            2'd2:    m = FB_CENTRE;
            default: m = FB_NATIVE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/fb_delay_line.sv
// Generic W-bit, N-stage shift register with a programmable reset value.
module fb_delay_line #(
    parameter int             W       = 1,
    parameter int             N       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_q [N];
    logic [W-1:0] stage_d [N];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < N; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[N-1];

endmodule

// File: rtl/fb_scaled_reader.sv
// Frame-buffer read controller: maps display coordinates to source addresses,
// hides BRAM latency and re-aligns de/syncs with the RGB output.
module fb_scaled_reader
    import fb_pkg::*;
#(
    parameter int SRC_W  = DEF_SRC_W,
    parameter int SRC_H  = DEF_SRC_H,
    parameter int DISP_W = DEF_DISP_W,
    parameter int DISP_H = DEF_DISP_H,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int PIX_W  = DEF_PIX_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           mode_i,
    input  logic [PIX_W-1:0]     border_rgb,
    input  logic [9:0]           x_coor,
    input  logic [9:0]           y_coor,
    input  logic                 display_en,
    input  logic                 h_sync_i,
    input  logic                 v_sync_i,
    output logic                 rclk,
    output logic [ADDR_W-1:0]    rAddr,
    input  logic [PIX_W-1:0]     rData,
    output logic                 de,
    output logic [PIX_W/3-1:0]   vgaRed,
    output logic [PIX_W/3-1:0]   vgaGreen,
    output logic [PIX_W/3-1:0]   vgaBlue,
    output logic                 h_sync_o,
    output logic                 v_sync_o
);

    localparam int CH_W = PIX_W / 3;
    localparam int OX   = (DISP_W - SRC_W) / 2;
    localparam int OY   = (DISP_H - SRC_H) / 2;

    // Coordinates are widened to 11 bits so 2*SRC_W style limits fit.
    localparam logic [10:0] W_LIM  = 11'(SRC_W);
    localparam logic [10:0] H_LIM  = 11'(SRC_H);
    localparam logic [10:0] W2_LIM = 11'(2 * SRC_W);
    localparam logic [10:0] H2_LIM = 11'(2 * SRC_H);
    localparam logic [10:0] OX_LO  = 11'(OX);
    localparam logic [10:0] OX_HI  = 11'(OX + SRC_W);
    localparam logic [10:0] OY_LO  = 11'(OY);
    localparam logic [10:0] OY_HI  = 11'(OY + SRC_H);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);

    fb_mode_e           mode_q, mode_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic [10:0]        ys_last_q, ys_last_d;
    logic [ADDR_W-1:0]  raddr_q, raddr_d;
    fb_ctl_t            ctl1_q, ctl1_d;
    fb_ctl_t            ctl_l;
    logic               de_q, de_d;
    logic               hso_q, hso_d;
    logic               vso_q, vso_d;
    logic [PIX_W-1:0]   rgb_q, rgb_d;

    logic               frame_start;
    logic               line_start;
    logic [10:0]        x_e, y_e;
    logic [10:0]        xs, ys;
    logic               x_in, y_in, hit;

    assign frame_start = (x_coor == 10'd0) && (y_coor == 10'd0);
    assign line_start  = (x_coor == 10'd0);
    assign x_e         = {1'b0, x_coor};
    assign y_e         = {1'b0, y_coor};

    // The new mode takes effect on the frame-start pixel itself.
    always_comb begin
        mode_d = frame_start ? fb_decode_mode(mode_i) : mode_q;
    end

    always_comb begin
        x_in = 1'b0;
        y_in = 1'b0;
        xs   = x_e;
        ys   = y_e;
        case (mode_d)
            FB_X2: begin
                x_in = (x_e < W2_LIM);
                y_in = (y_e < H2_LIM);
                xs   = {1'b0, x_e[10:1]};
                ys   = {1'b0, y_e[10:1]};
            end
            FB_CENTRE: begin
                x_in = (x_e >= OX_LO) && (x_e < OX_HI);
                y_in = (y_e >= OY_LO) && (y_e < OY_HI);
                xs   = x_e - OX_LO;
                ys   = y_e - OY_LO;
            end
            default: begin
                x_in = (x_e < W_LIM);
                y_in = (y_e < H_LIM);
                xs   = x_e;
                ys   = y_e;
            end
        endcase
        hit = display_en && x_in && y_in;
    end

    // Row base advances by one source line whenever ys moves on, so a
    // repeated line in 2x mode re-reads the same row without a multiply.
    always_comb begin
        row_base_d = row_base_q;
        ys_last_d  = ys_last_q;
        if (line_start) begin
            if (!y_in || (ys == 11'd0)) begin
                row_base_d = '0;
            end else if (ys != ys_last_q) begin
                row_base_d = row_base_q + ROW_STEP;
            end
            ys_last_d = y_in ? ys : 11'd0;
        end
    end

    always_comb begin
        raddr_d    = hit ? (row_base_d + ADDR_W'(xs)) : '0;
        ctl1_d.hit = hit;
        ctl1_d.act = display_en;
        ctl1_d.hs  = h_sync_i;
        ctl1_d.vs  = v_sync_i;
    end

    fb_delay_line #(
        .W       ($bits(fb_ctl_t)),
        .N       (RD_LAT),
        .RST_VAL (CTL_RST)
    ) u_align (
        .clk   (clk),
        .rst_n (reset_n),
        .din   (ctl1_q),
        .dout  (ctl_l)
    );

    always_comb begin
        de_d  = ctl_l.act;
        hso_d = ctl_l.hs;
        vso_d = ctl_l.vs;
        if (ctl_l.hit) begin
            rgb_d = rData;
        end else if (ctl_l.act) begin
            rgb_d = border_rgb;
        end else begin
            rgb_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q     <= FB_NATIVE;
            row_base_q <= '0;
            ys_last_q  <= '0;
            raddr_q    <= '0;
            ctl1_q     <= CTL_RST;
            de_q       <= 1'b0;
            hso_q      <= 1'b1;
            vso_q      <= 1'b1;
            rgb_q      <= '0;
        end else begin
            mode_q     <= mode_d;
            row_base_q <= row_base_d;
            ys_last_q  <= ys_last_d;
            raddr_q    <= raddr_d;
            ctl1_q     <= ctl1_d;
            de_q       <= de_d;
            hso_q      <= hso_d;
            vso_q      <= vso_d;
            rgb_q      <= rgb_d;
        end
    end

    assign rclk     = clk;
    assign rAddr    = raddr_q;
    assign de       = de_q;
    assign h_sync_o = hso_q;
    assign v_sync_o = vso_q;
    assign vgaRed   = rgb_q[3*CH_W-1 -: CH_W];
    assign vgaGreen = rgb_q[2*CH_W-1 -: CH_W];
    assign vgaBlue  = rgb_q[CH_W-1:0];

endmodule
